// File: rtl/id_pkg.sv
// Shared decode constants: opcodes, EX commands, instruction field positions
// and the ID/EX control payload.
package id_pkg;

  localparam int unsigned ILEN    = 32;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned CMD_W   = 4;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned FUNCT_W = 4;

  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned FUNCT_LSB = 0;
  localparam int unsigned IMM_LSB   = 0;

  localparam logic [OP_W-1:0] OP_NOP  = 6'h00;
  localparam logic [OP_W-1:0] OP_RALU = 6'h01;
  localparam logic [OP_W-1:0] OP_ADDI = 6'h02;
  localparam logic [OP_W-1:0] OP_LW   = 6'h03;
  localparam logic [OP_W-1:0] OP_SW   = 6'h04;
  localparam logic [OP_W-1:0] OP_BEZ  = 6'h05;
  localparam logic [OP_W-1:0] OP_BNE  = 6'h06;
  localparam logic [OP_W-1:0] OP_JMP  = 6'h07;

  localparam logic [CMD_W-1:0] CMD_NONE = 4'h0;
  localparam logic [CMD_W-1:0] CMD_ADD  = 4'h1;

  typedef struct packed {
    logic             valid;
    logic [CMD_W-1:0] cmd;
    logic             mem_read;
    logic             mem_write;
    logic             wb_enable;
  } id_ctrl_t;

endpackage

// File: rtl/id_reg_file.sv
// NREG x XLEN register file, two combinational read ports, one write port.
// Register 0 reads zero and ignores writes. With ID_BYPASS_EN defined, a read
// of the index being written this cycle returns the write data directly.
module id_reg_file #(
  parameter  int unsigned XLEN = 32,
  parameter  int unsigned NREG = 32,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_dest,
  input  logic [XLEN-1:0] wb_data,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1_c,
  output logic [XLEN-1:0] rdata2_c
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  // Next register contents: apply the writeback, never to register 0
  always_comb begin
    regs_d = regs_q;
    if (wb_en && (wb_dest != '0)) regs_d[wb_dest] = wb_data;
  end

  // Storage with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  // Read ports, register 0 hardwired to zero
  always_comb begin
    rdata1_c = (raddr1 == '0) ? '0 : regs_q[raddr1];
    rdata2_c = (raddr2 == '0) ? '0 : regs_q[raddr2];
`ifdef ID_BYPASS_EN
    if (wb_en && (wb_dest != '0) && (wb_dest == raddr1)) rdata1_c = wb_data;
    if (wb_en && (wb_dest != '0) && (wb_dest == raddr2)) rdata2_c = wb_data;
`endif
  end

endmodule

// File: rtl/id_decode_unit.sv
// Instruction decode stage: field decode, register read, load-use and
// writeback hazard detection, branch resolution and the ID/EX register.
// Build option ID_BYPASS_EN: same-cycle writeback forwarding into the read
// ports; without it a read of the register being written stalls one cycle.
module id_decode_unit
  import id_pkg::*;
#(
  parameter  int unsigned XLEN = 32,
  parameter  int unsigned NREG = 32,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      instr,
  input  logic             ex_stall,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_dest,
  input  logic [XLEN-1:0]  wb_data,
  output logic             stall,
  output logic             branch_taken,
  output logic [31:0]      branch_target,
  output logic             illegal,
  output logic             ex_valid,
  output logic [CMD_W-1:0] ex_cmd,
  output logic             mem_read,
  output logic             mem_write,
  output logic             wb_enable,
  output logic [AW-1:0]    dest,
  output logic [XLEN-1:0]  reg1,
  output logic [XLEN-1:0]  reg2,
  output logic [XLEN-1:0]  val2,
  output logic [31:0]      pc_out
);

  logic [OP_W-1:0]    op;
  logic [AW-1:0]      rs_idx, rt_idx, rd_idx;
  logic [XLEN-1:0]    imm_x;
  logic [31:0]        imm_32;
  logic               uses_rs, uses_rt, use_imm;
  logic               is_jmp, is_bez, is_bne, illegal_op;
  id_ctrl_t           ctrl_dec;
  logic [AW-1:0]      dest_dec;
  logic [XLEN-1:0]    rs_val_c, rt_val_c;
  logic               lu_hazard, wb_hazard, hazard;

  id_ctrl_t           ctrl_q, ctrl_d;
  logic [AW-1:0]      dest_q, dest_d;
  logic [XLEN-1:0]    reg1_q, reg1_d, reg2_q, reg2_d, val2_q, val2_d;
  logic [31:0]        pc_q, pc_d;

  id_reg_file #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .wb_en    (wb_en),
    .wb_dest  (wb_dest),
    .wb_data  (wb_data),
    .raddr1   (rs_idx),
    .raddr2   (rt_idx),
    .rdata1_c (rs_val_c),
    .rdata2_c (rt_val_c)
  );

  // Field extraction and opcode decode into control, sources and destination
  always_comb begin
    op         = instr[OP_LSB +: OP_W];
    rs_idx     = instr[RS_LSB +: AW];
    rt_idx     = instr[RT_LSB +: AW];
    rd_idx     = instr[RD_LSB +: AW];
    imm_x      = {{(XLEN-IMM_W){instr[IMM_LSB+IMM_W-1]}}, instr[IMM_LSB +: IMM_W]};
    imm_32     = {{(32-IMM_W){instr[IMM_LSB+IMM_W-1]}}, instr[IMM_LSB +: IMM_W]};
    uses_rs    = 1'b0;
    uses_rt    = 1'b0;
    use_imm    = 1'b0;
    is_jmp     = 1'b0;
    is_bez     = 1'b0;
    is_bne     = 1'b0;
    illegal_op = 1'b0;
    ctrl_dec   = '0;
    dest_dec   = '0;
    case (op)
      OP_NOP: ;
      OP_RALU: begin
        uses_rs            = 1'b1;
        uses_rt            = 1'b1;
        ctrl_dec.cmd       = instr[FUNCT_LSB +: FUNCT_W];
        dest_dec           = rd_idx;
        ctrl_dec.wb_enable = (rd_idx != '0);
      end
      OP_ADDI: begin
        uses_rs            = 1'b1;
        use_imm            = 1'b1;
        ctrl_dec.cmd       = CMD_ADD;
        dest_dec           = rt_idx;
        ctrl_dec.wb_enable = (rt_idx != '0);
      end
      OP_LW: begin
        uses_rs            = 1'b1;
        use_imm            = 1'b1;
        ctrl_dec.cmd       = CMD_ADD;
        ctrl_dec.mem_read  = 1'b1;
        dest_dec           = rt_idx;
        ctrl_dec.wb_enable = (rt_idx != '0);
      end
      OP_SW: begin
        uses_rs            = 1'b1;
        uses_rt            = 1'b1;
        use_imm            = 1'b1;
        ctrl_dec.cmd       = CMD_ADD;
        ctrl_dec.mem_write = 1'b1;
      end
      OP_BEZ: begin
        uses_rs = 1'b1;
        is_bez  = 1'b1;
      end
      OP_BNE: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
        is_bne  = 1'b1;
      end
      OP_JMP:  is_jmp = 1'b1;
      default: illegal_op = 1'b1;
    endcase
  end

  // Hazards, stall and branch resolution; all held quiet during reset
  always_comb begin
    lu_hazard = in_valid && ctrl_q.valid && ctrl_q.mem_read && (dest_q != '0) &&
                ((uses_rs && (dest_q == rs_idx)) || (uses_rt && (dest_q == rt_idx)));
`ifdef ID_BYPASS_EN
    wb_hazard = 1'b0;
`else
    wb_hazard = in_valid && wb_en && (wb_dest != '0) &&
                ((uses_rs && (wb_dest == rs_idx)) || (uses_rt && (wb_dest == rt_idx)));
`endif
    hazard        = lu_hazard || wb_hazard;
    stall         = !rst && (ex_stall || hazard);
    illegal       = !rst && in_valid && illegal_op;
    branch_taken  = !rst && in_valid && !stall &&
                    (is_jmp || (is_bez && (rs_val_c == '0)) ||
                     (is_bne && (rs_val_c != rt_val_c)));
    branch_target = pc_in + {imm_32[29:0], 2'b00};
  end

  // ID/EX next state: hold on EX back-pressure, bubble on a hazard
  always_comb begin
    ctrl_d = ctrl_q;
    dest_d = dest_q;
    reg1_d = reg1_q;
    reg2_d = reg2_q;
    val2_d = val2_q;
    pc_d   = pc_q;
    if (!ex_stall) begin
      if (hazard || !in_valid) begin
        ctrl_d = '0;
        dest_d = '0;
        reg1_d = '0;
        reg2_d = '0;
        val2_d = '0;
        pc_d   = '0;
      end else begin
        ctrl_d       = ctrl_dec;
        ctrl_d.valid = 1'b1;
        dest_d       = dest_dec;
        reg1_d       = rs_val_c;
        reg2_d       = rt_val_c;
        val2_d       = use_imm ? imm_x : rt_val_c;
        pc_d         = pc_in;
      end
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
      dest_q <= '0;
      reg1_q <= '0;
      reg2_q <= '0;
      val2_q <= '0;
      pc_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      dest_q <= dest_d;
      reg1_q <= reg1_d;
      reg2_q <= reg2_d;
      val2_q <= val2_d;
      pc_q   <= pc_d;
    end
  end

  assign ex_valid  = ctrl_q.valid;
  assign ex_cmd    = ctrl_q.cmd;
  assign mem_read  = ctrl_q.mem_read;
  assign mem_write = ctrl_q.mem_write;
  assign wb_enable = ctrl_q.wb_enable;
  assign dest      = dest_q;
  assign reg1      = reg1_q;
  assign reg2      = reg2_q;
  assign val2      = val2_q;
  assign pc_out    = pc_q;

endmodule

// File: tb/tb_id_decode_unit.sv
// Bench for id_decode_unit: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the decode stage.
module tb_id_decode_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
`ifdef ID_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst, in_valid, ex_stall, wb_en;
  logic [31:0]     pc_in, instr;
  logic [AW-1:0]   wb_dest;
  logic [XLEN-1:0] wb_data;
  logic            stall, branch_taken, illegal;
  logic [31:0]     branch_target, pc_out;
  logic            ex_valid, mem_read, mem_write, wb_enable;
  logic [3:0]      ex_cmd;
  logic [AW-1:0]   dest;
  logic [XLEN-1:0] reg1, reg2, val2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_decode_unit #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .pc_in(pc_in), .instr(instr),
    .ex_stall(ex_stall), .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .illegal(illegal), .ex_valid(ex_valid), .ex_cmd(ex_cmd), .mem_read(mem_read),
    .mem_write(mem_write), .wb_enable(wb_enable), .dest(dest), .reg1(reg1),
    .reg2(reg2), .val2(val2), .pc_out(pc_out)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    logic            v;
    logic [3:0]      cmd;
    logic            mr, mw, wbe;
    logic [AW-1:0]   dest;
    logic [XLEN-1:0] r1, r2, v2;
    logic [31:0]     pc;
  } ex_t;

  typedef struct {
    bit legal, rd_rs, rd_rt, use_imm, mr, mw, writes;
    int cmd, dest, kind;
  } dec_t;

  logic [XLEN-1:0] m_regs [NREG];
  ex_t             m_ex;

  function automatic dec_t m_decode(input logic [31:0] w);
    dec_t d;
    int op, rt, rd;
    op = int'(w[31:26]);
    rt = int'(w[20:16]) % NREG;
    rd = int'(w[15:11]) % NREG;
    d = '{default: 0};
    d.legal = (op <= 7);
    d.kind  = op;
    case (op)
      1: begin d.rd_rs = 1; d.rd_rt = 1; d.cmd = int'(w[3:0]); d.dest = rd; d.writes = 1; end
      2: begin d.rd_rs = 1; d.use_imm = 1; d.cmd = 1; d.dest = rt; d.writes = 1; end
      3: begin d.rd_rs = 1; d.use_imm = 1; d.cmd = 1; d.dest = rt; d.writes = 1; d.mr = 1; end
      4: begin d.rd_rs = 1; d.rd_rt = 1; d.use_imm = 1; d.cmd = 1; d.mw = 1; end
      5: d.rd_rs = 1;
      6: begin d.rd_rs = 1; d.rd_rt = 1; end
      default: ;
    endcase
    return d;
  endfunction

  function automatic int f_rs(); return int'(instr[25:21]) % NREG; endfunction
  function automatic int f_rt(); return int'(instr[20:16]) % NREG; endfunction

  function automatic logic [XLEN-1:0] m_read(input int idx);
    if (idx == 0) return '0;
    if (BYPASS && wb_en && (int'(wb_dest) == idx)) return wb_data;
    return m_regs[idx];
  endfunction

  function automatic bit m_reads(input dec_t d, input int r);
    return (d.rd_rs && f_rs() == r) || (d.rd_rt && f_rt() == r);
  endfunction

  function automatic bit m_hazard();
    dec_t d;
    bit lu, wbh;
    d   = m_decode(instr);
    lu  = in_valid && m_ex.v && m_ex.mr && (m_ex.dest != 0) && m_reads(d, int'(m_ex.dest));
    wbh = !BYPASS && in_valid && wb_en && (wb_dest != 0) && m_reads(d, int'(wb_dest));
    return lu || wbh;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic check_outputs();
    dec_t d;
    bit e_stall, e_bt, e_ill, cond;
    int off;
    d       = m_decode(instr);
    e_stall = !rst && (ex_stall || m_hazard());
    cond    = (d.kind == 7) || (d.kind == 5 && m_read(f_rs()) == 0) ||
              (d.kind == 6 && m_read(f_rs()) != m_read(f_rt()));
    e_bt    = !rst && in_valid && !e_stall && cond;
    e_ill   = !rst && in_valid && !d.legal;
    off     = int'($signed(instr[15:0]));
    chk("stall", 64'(stall), 64'(e_stall));
    chk("branch_taken", 64'(branch_taken), 64'(e_bt));
    chk("branch_target", 64'(branch_target), 64'(32'(pc_in + 32'(off * 4))));
    chk("illegal", 64'(illegal), 64'(e_ill));
    chk("ex_valid", 64'(ex_valid), 64'(m_ex.v));
    chk("ex_cmd", 64'(ex_cmd), 64'(m_ex.cmd));
    chk("mem_read", 64'(mem_read), 64'(m_ex.mr));
    chk("mem_write", 64'(mem_write), 64'(m_ex.mw));
    chk("wb_enable", 64'(wb_enable), 64'(m_ex.wbe));
    chk("dest", 64'(dest), 64'(m_ex.dest));
    chk("reg1", 64'(reg1), 64'(m_ex.r1));
    chk("reg2", 64'(reg2), 64'(m_ex.r2));
    chk("val2", 64'(val2), 64'(m_ex.v2));
    chk("pc_out", 64'(pc_out), 64'(m_ex.pc));
  endtask

  task automatic advance_model();
    dec_t d;
    ex_t  nx;
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_ex = '{default: '0};
      return;
    end
    d  = m_decode(instr);
    nx = m_ex;
    if (!ex_stall) begin
      nx = '{default: '0};
      if (in_valid && !m_hazard()) begin
        nx.v    = 1'b1;
        nx.cmd  = 4'(d.cmd);
        nx.mr   = d.mr;
        nx.mw   = d.mw;
        nx.wbe  = d.writes && (d.dest != 0);
        nx.dest = AW'(d.dest);
        nx.r1   = m_read(f_rs());
        nx.r2   = m_read(f_rt());
        nx.v2   = d.use_imm ? XLEN'($signed(instr[15:0])) : nx.r2;
        nx.pc   = pc_in;
      end
    end
    if (wb_en && wb_dest != 0) m_regs[wb_dest] = wb_data;
    m_ex = nx;
  endtask

  // One clock: compare mid-cycle, update model, land just after the edge
  task automatic step();
    @(negedge clk);
    check_outputs();
    advance_model();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_r(input int rs, input int rt, input int rd, input int fn);
    return {6'h01, 5'(rs), 5'(rt), 5'(rd), 7'h00, 4'(fn)};
  endfunction

  function automatic logic [31:0] mk_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; pc_in = '0; instr = '0; ex_stall = 1'b0;
    wb_en = 1'b0; wb_dest = '0; wb_data = '0;
    foreach (m_regs[i]) m_regs[i] = '0;
    m_ex = '{default: '0};
    step();
    step();
    chk("reset_ex_valid", 64'(ex_valid), 64'(0));
    chk("reset_stall", 64'(stall), 64'(0));
    rst = 1'b0;

    // preload r1=0x10, r2=0x20
    wb_en = 1'b1; wb_dest = 5'd1; wb_data = 32'h10; step();
    wb_dest = 5'd2; wb_data = 32'h20; step();
    wb_en = 1'b0;

    // ADDI rt=3 imm=0xFFFF
    in_valid = 1'b1; pc_in = 32'h40; instr = mk_i(2, 0, 3, 16'hFFFF); step();
    chk("addi_ex_valid", 64'(ex_valid), 64'(1));
    chk("addi_dest", 64'(dest), 64'(3));
    chk("addi_val2", 64'(val2), 64'(32'hFFFF_FFFF));
    chk("addi_wb_enable", 64'(wb_enable), 64'(1));

    // BNE r1 != r2, imm=4, pc_in=0x100
    instr = mk_i(6, 1, 2, 4); pc_in = 32'h100; #1;
    chk("bne_taken", 64'(branch_taken), 64'(1));
    chk("bne_target", 64'(branch_target), 64'(32'h110));
    step();

    // load-use: LW r5 then R-ALU reading r5
    instr = mk_i(3, 0, 5, 8); step();
    instr = mk_r(5, 0, 6, 3); #1;
    chk("lu_stall", 64'(stall), 64'(1));
    step();
    chk("lu_bubble", 64'(ex_valid), 64'(0));
    chk("lu_stall_released", 64'(stall), 64'(0));
    step();
    chk("lu_issue_valid", 64'(ex_valid), 64'(1));
    chk("lu_issue_cmd", 64'(ex_cmd), 64'(3));
    chk("lu_issue_dest", 64'(dest), 64'(6));

    // writeback of r7 while reading r7
    instr = mk_r(7, 0, 8, 0); wb_en = 1'b1; wb_dest = 5'd7; wb_data = 32'hAB;
`ifdef ID_BYPASS_EN
    #1;
    chk("byp_no_stall", 64'(stall), 64'(0));
    step();
    wb_en = 1'b0;
    chk("byp_reg1", 64'(reg1), 64'(32'hAB));
`else
    #1;
    chk("wbh_stall", 64'(stall), 64'(1));
    step();
    wb_en = 1'b0; #1;
    chk("wbh_stall_released", 64'(stall), 64'(0));
    step();
    chk("wbh_reg1", 64'(reg1), 64'(32'hAB));
`endif

    // EX back-pressure for 3 cycles holds ID/EX
    instr = mk_i(2, 1, 9, 5); step();
    ex_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      instr = mk_r(k + 1, 2, 10, k); #1;
      chk("exs_stall", 64'(stall), 64'(1));
      step();
      chk("exs_hold_dest", 64'(dest), 64'(9));
      chk("exs_hold_val2", 64'(val2), 64'(5));
      chk("exs_hold_reg1", 64'(reg1), 64'(32'h10));
    end
    ex_stall = 1'b0;

    // undefined opcode
    instr = mk_i(63, 0, 0, 0); #1;
    chk("ill_flag", 64'(illegal), 64'(1));
    step();
    chk("ill_ex_valid", 64'(ex_valid), 64'(1));
    chk("ill_cmd", 64'(ex_cmd), 64'(0));
    chk("ill_wb_enable", 64'(wb_enable), 64'(0));
    chk("ill_mem_read", 64'(mem_read), 64'(0));

    // reset during a load-use stall
    instr = mk_i(3, 0, 4, 0); step();
    instr = mk_r(4, 4, 11, 0); #1;
    chk("rst_pre_stall", 64'(stall), 64'(1));
    rst = 1'b1; #1;
    chk("rst_stall_gated", 64'(stall), 64'(0));
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_ex_valid_clear", 64'(ex_valid), 64'(0));
    chk("rst_dest_clear", 64'(dest), 64'(0));
    chk("rst_reg1_clear", 64'(reg1), 64'(0));
    chk("rst_pc_clear", 64'(pc_out), 64'(0));
    wb_en = 1'b1; wb_dest = 5'd0; wb_data = 32'hFFFF_FFFF; step();
    wb_en = 1'b0;
    for (int r = 0; r < int'(NREG); r++) begin
      in_valid = 1'b1; instr = mk_r(r, r, 1, 0); step();
      chk("post_rst_read", 64'(reg1), 64'(0));
    end

    // random traffic
    for (int c = 0; c < 400; c++) begin
      int sel;
      logic [5:0] opv;
      rst      = ($urandom_range(0, 63) == 0);
      in_valid = ($urandom_range(0, 7) != 0);
      ex_stall = ($urandom_range(0, 7) == 0);
      wb_en    = 1'($urandom_range(0, 1));
      wb_dest  = AW'($urandom_range(0, 7));
      wb_data  = XLEN'($urandom());
      pc_in    = $urandom();
      sel      = int'($urandom_range(0, 8));
      opv      = (sel == 8) ? 6'($urandom_range(8, 63)) : 6'(sel);
      instr    = {opv, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 11'($urandom())};
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_decode_unit.md
ID_DECODE_UNIT -- requirements
Module: id_decode_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width (32 or 64).
REQ-002 Parameter NREG, default 32, register count (8, 16 or 32); AW = log2(NREG); register indices use the low AW bits of each 5-bit instruction field.
REQ-003 The block SHALL have one clock, clk, and reset rst, which is synchronous and active-high.
REQ-004 Ports:
- clk  in  1  clock
- rst  in  1  sync active-high reset
- in_valid  in  1  IF/ID holds a live instruction
- pc_in  in  32  PC+4 of that instruction
- instr  in  32  instruction word
- ex_stall  in  1  EX back-pressure
- wb_en, wb_dest, wb_data  in  1/AW/XLEN  writeback port
- stall  out  1  hold IF and IF/ID this cycle
- branch_taken  out  1  redirect fetch
- branch_target  out  32  redirect address
- illegal  out  1  undefined opcode decoded
- ex_valid, ex_cmd, mem_read, mem_write, wb_enable  out  1/4/1/1/1  ID/EX control
- dest  out  AW  ID/EX destination
- reg1, reg2, val2  out  XLEN  ID/EX operands; val2 = immediate or reg2
- pc_out  out  32  ID/EX PC

Function
REQ-005 Fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[3:0], imm=[15:0], sign-extended to XLEN.
REQ-006 Decode: 0x00 NOP; 0x01 R-ALU (ex_cmd=funct, dest=rd, reads rs,rt); 0x02 ADDI (ex_cmd=0x1, dest=rt, val2=imm); 0x03 LW (mem_read, ex_cmd=0x1, dest=rt); 0x04 SW (mem_write, ex_cmd=0x1, reads rt, wb off); 0x05 BEZ (reads rs); 0x06 BNE (reads rs,rt); 0x07 JMP. Any other opcode SHALL behave as NOP with illegal=1 while in_valid.
REQ-007 wb_enable SHALL be 1 only for R-ALU, ADDI and LW with dest != 0.
REQ-008 Register 0 SHALL read zero; writes to it SHALL be discarded.
REQ-009 Branch resolved in ID: branch_taken = in_valid & !stall & (JMP | BEZ&rs==0 | BNE&rs!=rt); branch_target = pc_in + (sext(imm)<<2), truncated to 32 bits; both combinational.
REQ-010 Load-use: stall SHALL assert when ex_valid & mem_read & dest!=0 and dest equals a register read by the current valid instruction.
REQ-011 stall SHALL also assert when ex_stall=1.
REQ-012 Latency: one cycle; on a clk edge with stall=0 the ID/EX registers SHALL capture the decoded instruction with ex_valid=in_valid.
REQ-013 Load-use stall with ex_stall=0: ID/EX SHALL load a bubble (ex_valid=0, all control zero).
REQ-014 ex_stall=1: ID/EX SHALL hold its contents unchanged.
REQ-015 When ex_valid=0, mem_read, mem_write and wb_enable SHALL be 0.
REQ-016 Register-file write occurs on the clk edge when wb_en=1; simultaneous read and write of the same index is governed by REQ-019/020.

Reset
REQ-017 While rst=1 at a clk edge: all registers, all ID/EX outputs and ex_valid SHALL become zero; stall, branch_taken and illegal SHALL be 0 during reset.
REQ-018 A rst in mid-stall SHALL discard the stalled instruction; no partial state survives.

Configuration
REQ-019 With ID_BYPASS_EN defined: a read whose index equals wb_dest while wb_en=1 (index != 0) SHALL return wb_data in the same cycle.
REQ-020 Without ID_BYPASS_EN: that condition SHALL assert stall for one cycle and the read SHALL return the written value on the next cycle.

Structure
REQ-021 Shared package id_pkg: opcode constants, ex_cmd constants, and field-position constants.
REQ-022 Sub-module id_reg_file (NREG x XLEN, 2 read, 1 write, sync reset, bypass under ID_BYPASS_EN); hazard and decode logic stay in id_decode_unit.

Verification
REQ-023 ADDI rt=3 imm=0xFFFF, in_valid -> next cycle ex_valid=1, dest=3, val2=all-ones, wb_enable=1.
REQ-024 LW dest=5 in EX, then R-ALU reading r5 -> stall=1 one cycle, bubble ex_valid=0, then R-ALU issues.
REQ-025 BNE rs=1 (0x10), rt=2 (0x20), imm=0x0004, pc_in=0x100 -> branch_taken=1, branch_target=0x110.
REQ-026 wb_en dest=7 data=0xAB while reading r7 -> reg1=0xAB with ID_BYPASS_EN; without it, one stall, then 0xAB.
REQ-027 ex_stall=1 for 3 cycles -> ID/EX outputs are constant and stall=1 throughout; op=0x3F -> illegal=1, ex_valid=1 with NOP controls.
REQ-028 rst mid-stall -> all outputs 0 next cycle; r1..r(NREG-1) read zero; write to r0 ignored.
